// File: rtl/inst_mem_loadable_pkg.sv
// Shared definitions for the loadable instruction memory and its CPU-level users.
package inst_mem_loadable_pkg;

   // Loader / fetch controller states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   // Defaults used by the CPU top when instantiating the memory
   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned ADDR_W_DEF = 6;
   localparam logic [31:0] NOP_DEF    = 32'h0000_0000;

endpackage

// File: rtl/imem_ram_1r1w.sv
// DEPTH x DATA_W storage: synchronous write port, registered read port.
// Contents are never reset so a loaded program survives rst.
module imem_ram_1r1w #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 6
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Write port: store the word on each enabled edge
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read port: capture the addressed word; holds when re is low
   always_ff @(posedge clk) begin
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/inst_mem_loadable.sv
// Boot-loadable instruction memory serving the IF stage: streaming loader,
// 1-cycle registered fetch with stall hold, flush-to-NOP and address faults.
module inst_mem_loadable
   import inst_mem_loadable_pkg::*;
#(
   parameter int unsigned          DATA_W = DATA_W_DEF,
   parameter int unsigned          ADDR_W = ADDR_W_DEF,
   parameter logic [DATA_W-1:0]    NOP    = NOP_DEF[DATA_W-1:0]
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              boot_start,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   output logic              load_done,
   output logic              load_err,
   input  logic [31:0]       pc,
   input  logic              fetch_en,
   input  logic              stall,
   input  logic              flush,
   output logic [DATA_W-1:0] inst,
   output logic              inst_valid,
   output logic              addr_fault
);

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic              pc_bad;
   logic              ram_we;
   logic              ram_re;
   logic [DATA_W-1:0] ram_rdata;

   // Fetch address checks and RAM port controls
   always_comb begin
      pc_bad = (pc[1:0] != 2'b00) || ((pc >> (ADDR_W + 2)) != '0);
      ram_we = (state == LOAD) && ld_valid;
      ram_re = (state == RUN) && !boot_start && !flush && !stall && fetch_en && !pc_bad;
   end

   imem_ram_1r1w #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ptr),
      .wdata (ld_data),
      .re    (ram_re),
      .raddr (pc[ADDR_W+1:2]),
      .rdata (ram_rdata)
   );

   // The RAM read register is the inst flop; inst_valid gates it so that a
   // stall simply leaves both untouched, and flush/reset force NOP at once.
   always_comb begin
      inst = inst_valid ? ram_rdata : NOP;
   end

   // Loader FSM and fetch status registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         ptr        <= '0;
         ld_ready   <= 1'b0;
         load_done  <= 1'b0;
         load_err   <= 1'b0;
         inst_valid <= 1'b0;
         addr_fault <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               inst_valid <= 1'b0;
               addr_fault <= 1'b0;
               if (boot_start) begin
                  state    <= LOAD;
                  ptr      <= '0;
                  ld_ready <= 1'b1;
               end
            end
            LOAD: begin
               inst_valid <= 1'b0;
               addr_fault <= 1'b0;
               if (ld_valid) begin
                  ptr <= ptr + 1'b1;
                  if (ld_last || (ptr == '1)) begin
                     state     <= RUN;
                     ld_ready  <= 1'b0;
                     load_done <= 1'b1;
                     if (!ld_last) begin
                        load_err <= 1'b1;
                     end
                  end
               end
            end
            RUN: begin
               if (boot_start) begin
                  state      <= LOAD;
                  ptr        <= '0;
                  ld_ready   <= 1'b1;
                  load_done  <= 1'b0;
                  load_err   <= 1'b0;
                  inst_valid <= 1'b0;
                  addr_fault <= 1'b0;
               end else if (flush) begin
                  inst_valid <= 1'b0;
                  addr_fault <= 1'b0;
               end else if (stall) begin
                  inst_valid <= inst_valid;
                  addr_fault <= addr_fault;
               end else if (fetch_en) begin
                  inst_valid <= !pc_bad;
                  addr_fault <= pc_bad;
               end else begin
                  inst_valid <= 1'b0;
                  addr_fault <= 1'b0;
               end
            end
            default: begin
               state      <= IDLE;
               ld_ready   <= 1'b0;
               inst_valid <= 1'b0;
               addr_fault <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inst_mem_loadable.sv
// Directed self-checking bench for inst_mem_loadable.
module tb_inst_mem_loadable;

   logic        clk;
   logic        rst;
   logic        boot_start;
   logic        ld_valid;
   logic        ld_ready;
   logic [31:0] ld_data;
   logic        ld_last;
   logic        load_done;
   logic        load_err;
   logic [31:0] pc;
   logic        fetch_en;
   logic        stall;
   logic        flush;
   logic [31:0] inst;
   logic        inst_valid;
   logic        addr_fault;

   int checks;
   int failures;

   localparam logic [31:0] W0 = 32'h0010_0443;
   localparam logic [31:0] W1 = 32'h0020_1025;
   localparam logic [31:0] W2 = 32'h0410_18E1;

   inst_mem_loadable #(
      .DATA_W (32),
      .ADDR_W (6),
      .NOP    (32'h0000_0000)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .boot_start (boot_start),
      .ld_valid   (ld_valid),
      .ld_ready   (ld_ready),
      .ld_data    (ld_data),
      .ld_last    (ld_last),
      .load_done  (load_done),
      .load_err   (load_err),
      .pc         (pc),
      .fetch_en   (fetch_en),
      .stall      (stall),
      .flush      (flush),
      .inst       (inst),
      .inst_valid (inst_valid),
      .addr_fault (addr_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance one rising edge, then settle 1ns past it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; boot_start = 0; ld_valid = 0; ld_data = '0; ld_last = 0;
      pc = '0; fetch_en = 0; stall = 0; flush = 0;
      step(); step();
      checks++;
      if ({ld_ready, load_done, load_err, inst_valid, addr_fault} !== 5'b00000) begin
         failures++;
         $display("FAIL reset_flags got %b exp 00000", {ld_ready, load_done, load_err, inst_valid, addr_fault});
      end
      checks++;
      if (inst !== 32'h0) begin
         failures++;
         $display("FAIL reset_inst got %h exp 00000000", inst);
      end
      rst = 1'b0;
      step();
      checks++;
      if (ld_ready !== 1'b0) begin
         failures++;
         $display("FAIL idle_ready got %b exp 0", ld_ready);
      end
   endtask

   task automatic test_load3();
      logic [31:0] w [3];
      w[0] = W0; w[1] = W1; w[2] = W2;
      boot_start = 1'b1;
      step();
      boot_start = 1'b0;
      checks++;
      if ({ld_ready, load_done} !== 2'b10) begin
         failures++;
         $display("FAIL load3_enter got %b exp 10", {ld_ready, load_done});
      end
      for (int i = 0; i < 3; i++) begin
         ld_valid = 1'b1; ld_data = w[i]; ld_last = (i == 2);
         step();
         if (i < 2) begin
            checks++;
            if ({ld_ready, load_done} !== 2'b10) begin
               failures++;
               $display("FAIL load3_word%0d got %b exp 10", i, {ld_ready, load_done});
            end
         end
      end
      ld_valid = 1'b0; ld_last = 1'b0;
      checks++;
      if ({ld_ready, load_done, load_err} !== 3'b010) begin
         failures++;
         $display("FAIL load3_done got %b exp 010", {ld_ready, load_done, load_err});
      end
   endtask

   task automatic test_fetch_seq();
      logic [31:0] w [3];
      w[0] = W0; w[1] = W1; w[2] = W2;
      fetch_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         pc = 32'(i * 4);
         step();
         checks++;
         if ({inst_valid, addr_fault, inst} !== {2'b10, w[i]}) begin
            failures++;
            $display("FAIL fetch_pc%0d got v=%b f=%b %h exp v=1 f=0 %h", i * 4, inst_valid, addr_fault, inst, w[i]);
         end
      end
      fetch_en = 1'b0;
      step();
      checks++;
      if ({inst_valid, inst} !== {1'b0, 32'h0}) begin
         failures++;
         $display("FAIL fetch_idle got v=%b %h exp v=0 00000000", inst_valid, inst);
      end
   endtask

   task automatic test_stall_flush();
      fetch_en = 1'b1; pc = 32'd4;
      step();
      stall = 1'b1; pc = 32'd8;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({inst_valid, inst} !== {1'b1, W1}) begin
            failures++;
            $display("FAIL stall_hold%0d got v=%b %h exp v=1 %h", i, inst_valid, inst, W1);
         end
      end
      flush = 1'b1;
      step();
      checks++;
      if ({inst_valid, addr_fault, inst} !== {2'b00, 32'h0}) begin
         failures++;
         $display("FAIL flush got v=%b f=%b %h exp v=0 f=0 00000000", inst_valid, addr_fault, inst);
      end
      flush = 1'b0; stall = 1'b0; fetch_en = 1'b0;
      step();
   endtask

   task automatic test_overflow();
      boot_start = 1'b1;
      step();
      boot_start = 1'b0;
      checks++;
      if ({ld_ready, load_done, inst_valid} !== 3'b100) begin
         failures++;
         $display("FAIL ovf_enter got %b exp 100", {ld_ready, load_done, inst_valid});
      end
      for (int i = 0; i < 64; i++) begin
         ld_valid = 1'b1; ld_last = 1'b0; ld_data = 32'hA000_0000 + 32'(i);
         boot_start = (i == 10);
         step();
      end
      boot_start = 1'b0;
      checks++;
      if ({ld_ready, load_done, load_err} !== 3'b011) begin
         failures++;
         $display("FAIL ovf_err got %b exp 011", {ld_ready, load_done, load_err});
      end
      ld_data = 32'hDEAD_BEEF;
      step();
      ld_valid = 1'b0;
      checks++;
      if ({ld_ready, load_done, load_err} !== 3'b011) begin
         failures++;
         $display("FAIL ovf_65th got %b exp 011", {ld_ready, load_done, load_err});
      end
   endtask

   task automatic test_fault();
      fetch_en = 1'b1;
      pc = 32'h102;
      step();
      checks++;
      if ({inst_valid, addr_fault, inst} !== {2'b01, 32'h0}) begin
         failures++;
         $display("FAIL fault_misalign got v=%b f=%b %h exp v=0 f=1 00000000", inst_valid, addr_fault, inst);
      end
      pc = 32'h100;
      step();
      checks++;
      if ({inst_valid, addr_fault, inst} !== {2'b01, 32'h0}) begin
         failures++;
         $display("FAIL fault_range got v=%b f=%b %h exp v=0 f=1 00000000", inst_valid, addr_fault, inst);
      end
      pc = 32'hFC;
      step();
      checks++;
      if ({inst_valid, addr_fault, inst} !== {2'b10, 32'hA000_003F}) begin
         failures++;
         $display("FAIL fetch_word63 got v=%b f=%b %h exp v=1 f=0 a000003f", inst_valid, addr_fault, inst);
      end
      pc = 32'h8000_0000;
      step();
      checks++;
      if ({inst_valid, addr_fault} !== 2'b01) begin
         failures++;
         $display("FAIL fault_high got v=%b f=%b exp v=0 f=1", inst_valid, addr_fault);
      end
      pc = 32'h0;
      step();
      checks++;
      if ({inst_valid, addr_fault, inst} !== {2'b10, 32'hA000_0000}) begin
         failures++;
         $display("FAIL fetch_word0 got v=%b f=%b %h exp v=1 f=0 a0000000", inst_valid, addr_fault, inst);
      end
      fetch_en = 1'b0;
      boot_start = 1'b1;
      step();
      boot_start = 1'b0;
      checks++;
      if ({ld_ready, load_done, load_err, inst_valid} !== 4'b1000) begin
         failures++;
         $display("FAIL reboot_clear got %b exp 1000", {ld_ready, load_done, load_err, inst_valid});
      end
   endtask

   task automatic test_reset_midload();
      // already in LOAD from the reboot in test_fault
      ld_valid = 1'b1; ld_last = 1'b0;
      ld_data = 32'h1111_1111;
      step();
      ld_data = 32'h2222_2222;
      step();
      ld_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({ld_ready, load_done, load_err, inst_valid, addr_fault} !== 5'b00000) begin
         failures++;
         $display("FAIL async_rst got %b exp 00000", {ld_ready, load_done, load_err, inst_valid, addr_fault});
      end
      step();
      rst = 1'b0;
      step();
      boot_start = 1'b1;
      step();
      boot_start = 1'b0;
      ld_valid = 1'b1; ld_last = 1'b1; ld_data = 32'h3333_3333;
      step();
      ld_valid = 1'b0; ld_last = 1'b0;
      checks++;
      if ({ld_ready, load_done, load_err} !== 3'b010) begin
         failures++;
         $display("FAIL reload_done got %b exp 010", {ld_ready, load_done, load_err});
      end
      fetch_en = 1'b1; pc = 32'd4;
      step();
      checks++;
      if ({inst_valid, inst} !== {1'b1, 32'h2222_2222}) begin
         failures++;
         $display("FAIL persist_word1 got v=%b %h exp v=1 22222222", inst_valid, inst);
      end
      pc = 32'd0;
      step();
      checks++;
      if ({inst_valid, inst} !== {1'b1, 32'h3333_3333}) begin
         failures++;
         $display("FAIL reload_word0 got v=%b %h exp v=1 33333333", inst_valid, inst);
      end
      fetch_en = 1'b0;
      step();
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_load3();
      test_fetch_seq();
      test_stall_flush();
      test_overflow();
      test_fault();
      test_reset_midload();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
